ultrasonic_burst_sequencer: RTL and testbench
=============================================

# ultrasonic_burst_sequencer

Sequences one ultrasonic ping: transmit a carrier burst of programmable length, blank the receiver while the transducer rings down, then open a receive window of programmable length. Optionally re-arms automatically after a hold-off. Sits in the 40 MHz PLL domain between the control/switch logic and the transducer driver and ADC capture path. It replaces free-running divider counters with a single scheduled timebase.

## Interface
Parameters:
- CARRIER_HALF, 500: clocks per carrier half-period (40 MHz / 40 kHz / 2).
- BLANK_CYC, 4000: clocks of receiver blanking after the burst.
- HOLDOFF_CYC, 400000: clocks between the end of LISTEN and auto-restart.
- LISTEN_W, 20: width of the listen-length input.

Ports:
- iCLK  in  1  40 MHz PLL clock; all logic on the rising edge.
- iRST  in  1  synchronous, active-high reset.
- iSTART  in  1  one-cycle request to start a ping; honoured only in IDLE.
- iABORT  in  1  level; forces IDLE.
- iAUTO  in  1  1 = repeat pings after hold-off.
- iPULSES  in  8  carrier periods per burst; latched on start.
- iLISTEN  in  LISTEN_W  receive-window length in clocks; latched on start.
- oTX  out  1  carrier square wave to the driver.
- oTX_EN  out  1  high during BURST.
- oRX_WIN  out  1  high during LISTEN.
- oBUSY  out  1  high in any state except IDLE.
- oDONE  out  1  one-cycle pulse at the end of LISTEN.
- oCYCLES  out  8  count of completed pings, for the LEDs.

## Operation
- States: IDLE, BURST, BLANK, LISTEN, HOLDOFF.
- IDLE:
  - On iSTART, latch iPULSES and iLISTEN.
  - Go to BURST. If the latched pulses value is 0, go directly to BLANK.
- BURST:
  - oTX starts high and toggles every CARRIER_HALF clocks.
  - After pulses×2×CARRIER_HALF clocks, go to BLANK with oTX low.
- BLANK: lasts exactly BLANK_CYC clocks, then go to LISTEN.
- LISTEN:
  - Lasts the latched listen-length clocks; a value of 0 is treated as 1.
  - On the last cycle, assert oDONE for one cycle and increment oCYCLES (wraps 255→0).
  - Next state is HOLDOFF if iAUTO is high, else IDLE.
- HOLDOFF:
  - Lasts HOLDOFF_CYC clocks, then go to BURST reusing the latched values.
  - If iAUTO drops during HOLDOFF, go to IDLE at the next clock.
- iSTART outside IDLE is ignored.
- iABORT has priority over everything except iRST:
  - Next state is IDLE with oTX low.
  - No oDONE; oCYCLES is unchanged.
- iSTART and iABORT together in IDLE: stay in IDLE.
- Counters are sized by $clog2 of their maximum. The burst counter counts half-periods (9 bits covers 2×255).

## Timing
- Reset values: state IDLE; all outputs 0, including oCYCLES; latches 0.
- Reset mid-burst takes effect at the next edge: oTX is 0 in the cycle after iRST is sampled.
- iSTART sampled at edge N gives oTX=1, oTX_EN=1, oBUSY=1 from edge N+1 (1-cycle latency).
- Outputs are registered and glitch-free, with no combinational path from inputs to outputs.
- oRX_WIN rises exactly BLANK_CYC clocks after oTX_EN falls.
- oDONE coincides with the last oRX_WIN cycle.
- oRX_WIN, oBUSY and oTX_EN are mutually consistent every cycle: oTX_EN and oRX_WIN are never high together.

## Configuration
- Macro US_SEQ_CYCLE_COUNT_EN.
  - Defined: the oCYCLES counter is implemented as described.
  - Undefined: oCYCLES is tied to 0 and the counter is not synthesised; all other behaviour is identical.

## Structure
- Package us_seq_pkg holds:
  - the state enum (IDLE, BURST, BLANK, LISTEN, HOLDOFF);
  - the PULSE_W=8 and CYCLE_W=8 constants;
  - a helper for counter width.
- One sub-module, us_carrier_gen:
  - half-period counter with enable, producing oTX and a half-period strobe;
  - held in reset whenever the FSM is not in BURST.

## Test plan
Bench parameters: CARRIER_HALF=4, BLANK_CYC=10, HOLDOFF_CYC=20.
- Single ping, iPULSES=3, iLISTEN=16, iAUTO=0 → oTX toggles every 4 clocks for 24 clocks; 10 clocks blank; oRX_WIN high 16 clocks; one oDONE; oCYCLES=1; oBUSY low 1 clock after oDONE.
- iPULSES=0, iLISTEN=0 → no oTX activity; BLANK 10 clocks; oRX_WIN high 1 clock with oDONE.
- iAUTO=1, iPULSES=2, iLISTEN=8 → pings repeat with 20-clock hold-off; after 3 pings oCYCLES=3; dropping iAUTO in HOLDOFF → IDLE next clock.
- iABORT during LISTEN → IDLE next clock; no oDONE; oCYCLES unchanged. Also iSTART mid-BURST → ignored, burst length unchanged.
- iRST asserted mid-BURST → all outputs 0 next cycle. Also 256 pings → oCYCLES wraps to 0. Both are also run with US_SEQ_CYCLE_COUNT_EN undefined, where oCYCLES must stay 0.

Source files
------------

// File: rtl/us_seq_pkg.sv
// Shared types and sizing helpers for the ultrasonic burst sequencer.
package us_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBurst,
        StBlank,
        StListen,
        StHoldoff
    } us_state_e;

    localparam int unsigned PULSE_W = 8;
    localparam int unsigned CYCLE_W = 8;

    // Bits needed for a counter running 0 .. max_val-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/us_carrier_gen.sv
// Carrier square-wave generator: half-period counter that starts high on the first run cycle.
module us_carrier_gen
    import us_seq_pkg::*;
#(
    parameter int unsigned CARRIER_HALF = 500
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic tx_o,
    output logic half_o
);

    localparam int unsigned CntW = cnt_w(CARRIER_HALF);
    localparam logic [CntW-1:0] CntLast = CntW'(CARRIER_HALF - 1);

    logic [CntW-1:0] cnt_q;
    logic            tx_q;
    logic            active_q;

    // run_i is the next-cycle burst flag, so tx_q is already high in the first burst cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || !run_i) begin
            cnt_q    <= '0;
            tx_q     <= 1'b0;
            active_q <= 1'b0;
        end else if (!active_q) begin
            cnt_q    <= '0;
            tx_q     <= 1'b1;
            active_q <= 1'b1;
        end else if (cnt_q == CntLast) begin
            cnt_q <= '0;
            tx_q  <= ~tx_q;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign tx_o   = tx_q;
    assign half_o = active_q && (cnt_q == CntLast);

endmodule

// File: rtl/ultrasonic_burst_sequencer.sv
// One-ping sequencer: BURST -> BLANK -> LISTEN, optional auto re-arm through HOLDOFF.
// Macro US_SEQ_CYCLE_COUNT_EN enables the completed-ping counter on oCYCLES.
module ultrasonic_burst_sequencer
    import us_seq_pkg::*;
#(
    parameter int unsigned CARRIER_HALF = 500,
    parameter int unsigned BLANK_CYC    = 4000,
    parameter int unsigned HOLDOFF_CYC  = 400000,
    parameter int unsigned LISTEN_W     = 20
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iSTART,
    input  logic               iABORT,
    input  logic               iAUTO,
    input  logic [PULSE_W-1:0] iPULSES,
    input  logic [LISTEN_W-1:0] iLISTEN,
    output logic               oTX,
    output logic               oTX_EN,
    output logic               oRX_WIN,
    output logic               oBUSY,
    output logic               oDONE,
    output logic [CYCLE_W-1:0] oCYCLES
);

    localparam int unsigned BlankW = cnt_w(BLANK_CYC);
    localparam int unsigned HoldW  = cnt_w(HOLDOFF_CYC);
    localparam int unsigned TmrW0  = (BlankW > HoldW) ? BlankW : HoldW;
    localparam int unsigned TmrW   = (TmrW0 > LISTEN_W) ? TmrW0 : LISTEN_W;
    localparam int unsigned HalfW  = cnt_w(2 * ((2 ** PULSE_W) - 1));

    localparam logic [TmrW-1:0] BlankLast = TmrW'(BLANK_CYC - 1);
    localparam logic [TmrW-1:0] HoldLast  = TmrW'(HOLDOFF_CYC - 1);

    us_state_e             state_q, state_d;
    logic [TmrW-1:0]       timer_q, timer_d;
    logic [HalfW-1:0]      half_q, half_d;
    logic [PULSE_W-1:0]    pulses_q, pulses_d;
    logic [LISTEN_W-1:0]   listen_q, listen_d;
    logic                  tx_en_q, rx_win_q, busy_q, done_q;
    logic                  done_d;
    logic                  half_tick;
    logic                  carrier_run;
    logic [HalfW-1:0]      half_last;
    logic [TmrW-1:0]       listen_last;

    assign half_last   = HalfW'({pulses_q, 1'b0}) - HalfW'(1);
    // A zero listen length still yields a single receive cycle.
    assign listen_last = (listen_q == '0) ? '0 : (TmrW'(listen_q) - TmrW'(1));

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TmrW'(1);
        half_d   = half_q;
        pulses_d = pulses_q;
        listen_d = listen_q;

        if (iABORT) begin
            state_d = StIdle;
            timer_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    timer_d = '0;
                    if (iSTART) begin
                        pulses_d = iPULSES;
                        listen_d = iLISTEN;
                        state_d  = (iPULSES == '0) ? StBlank : StBurst;
                    end
                end
                StBurst: begin
                    timer_d = '0;
                    if (half_tick) begin
                        if (half_q == half_last) begin
                            state_d = StBlank;
                        end else begin
                            half_d = half_q + HalfW'(1);
                        end
                    end
                end
                StBlank: begin
                    if (timer_q == BlankLast) begin
                        state_d = StListen;
                        timer_d = '0;
                    end
                end
                StListen: begin
                    if (timer_q == listen_last) begin
                        state_d = iAUTO ? StHoldoff : StIdle;
                        timer_d = '0;
                    end
                end
                StHoldoff: begin
                    if (!iAUTO) begin
                        state_d = StIdle;
                        timer_d = '0;
                    end else if (timer_q == HoldLast) begin
                        state_d = (pulses_q == '0) ? StBlank : StBurst;
                        timer_d = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end

        if (state_d != StBurst) begin
            half_d = '0;
        end

        // Registered done must land on the final LISTEN cycle, so predict it from next state.
        done_d = (state_d == StListen) && (timer_d == listen_last);
    end

    assign carrier_run = (state_d == StBurst);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            half_q   <= '0;
            pulses_q <= '0;
            listen_q <= '0;
            tx_en_q  <= 1'b0;
            rx_win_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            half_q   <= half_d;
            pulses_q <= pulses_d;
            listen_q <= listen_d;
            tx_en_q  <= (state_d == StBurst);
            rx_win_q <= (state_d == StListen);
            busy_q   <= (state_d != StIdle);
            done_q   <= done_d;
        end
    end

    us_carrier_gen #(
        .CARRIER_HALF(CARRIER_HALF)
    ) u_carrier (
        .clk_i (iCLK),
        .rst_i (iRST),
        .run_i (carrier_run),
        .tx_o  (oTX),
        .half_o(half_tick)
    );

`ifdef US_SEQ_CYCLE_COUNT_EN
    logic [CYCLE_W-1:0] cycles_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cycles_q <= '0;
        end else if (done_d) begin
            cycles_q <= cycles_q + CYCLE_W'(1);
        end
    end

    assign oCYCLES = cycles_q;
`else
    assign oCYCLES = '0;
`endif

    assign oTX_EN  = tx_en_q;
    assign oRX_WIN = rx_win_q;
    assign oBUSY   = busy_q;
    assign oDONE   = done_q;

endmodule

// File: tb/tb_ultrasonic_burst_sequencer.sv
// Directed self-checking bench for ultrasonic_burst_sequencer (small timing parameters).
module tb_ultrasonic_burst_sequencer;

    localparam int unsigned Half  = 4;
    localparam int unsigned Blank = 10;
    localparam int unsigned Hold  = 20;
    localparam int unsigned LW    = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          auto_rp = 1'b0;
    logic [7:0]    pulses = 8'd0;
    logic [LW-1:0] listen = '0;
    logic          tx, tx_en, rx_win, busy, done;
    logic [7:0]    cycles;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_cycles = 8'd0;

    ultrasonic_burst_sequencer #(
        .CARRIER_HALF(Half),
        .BLANK_CYC   (Blank),
        .HOLDOFF_CYC (Hold),
        .LISTEN_W    (LW)
    ) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iSTART (start),
        .iABORT (abort),
        .iAUTO  (auto_rp),
        .iPULSES(pulses),
        .iLISTEN(listen),
        .oTX    (tx),
        .oTX_EN (tx_en),
        .oRX_WIN(rx_win),
        .oBUSY  (busy),
        .oDONE  (done),
        .oCYCLES(cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {tx, tx_en, rx_win, busy, done};
    endfunction

    function automatic logic [7:0] cyc_exp();
`ifdef US_SEQ_CYCLE_COUNT_EN
        return exp_cycles;
`else
        return 8'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Walks one ping from the first BURST (or BLANK) cycle; returns on the final LISTEN cycle.
    task automatic ping(input int p, input int l, input int poke);
        int   lw;
        logic b;
        lw = (l == 0) ? 1 : l;
        for (int i = 0; i < p * 2 * Half; i++) begin
            b = ((i / Half) % 2 == 0);
            chk("burst", {27'd0, outs()}, {27'd0, b, 4'b1010});
            if (i == poke) begin
                start  = 1'b1;
                pulses = 8'd9;
            end
            step();
            start = 1'b0;
        end
        for (int i = 0; i < Blank; i++) begin
            chk("blank", {27'd0, outs()}, 32'h02);
            step();
        end
        for (int i = 0; i < lw; i++) begin
            chk("listen", {27'd0, outs()}, {27'd0, 4'b0011, (i == lw - 1)});
            if (i < lw - 1) step();
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("reset_outs", {27'd0, outs()}, 32'h0);
        chk("reset_cycles", {24'd0, cycles}, {24'd0, cyc_exp()});

        // Single ping, 3 pulses, 16-cycle listen, no auto
        pulses = 8'd3;
        listen = 20'd16;
        start  = 1'b1;
        step();
        start  = 1'b0;
        pulses = 8'd7;
        listen = 20'd2;
        ping(3, 16, -1);
        exp_cycles++;
        chk("ping1_cycles", {24'd0, cycles}, {24'd0, cyc_exp()});
        step();
        chk("ping1_idle", {27'd0, outs()}, 32'h0);

        // Zero pulses and zero listen length
        pulses = 8'd0;
        listen = 20'd0;
        start  = 1'b1;
        step();
        start = 1'b0;
        ping(0, 0, -1);
        exp_cycles++;
        chk("zero_cycles", {24'd0, cycles}, {24'd0, cyc_exp()});
        step();
        chk("zero_idle", {27'd0, outs()}, 32'h0);

        // Auto re-arm: three pings separated by hold-off
        auto_rp = 1'b1;
        pulses  = 8'd2;
        listen  = 20'd8;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            ping(2, 8, -1);
            exp_cycles++;
            chk("auto_cycles", {24'd0, cycles}, {24'd0, cyc_exp()});
            step();
            if (n < 2) begin
                for (int i = 0; i < Hold; i++) begin
                    chk("holdoff", {27'd0, outs()}, 32'h02);
                    step();
                end
            end
        end
        chk("holdoff_busy", {27'd0, outs()}, 32'h02);
        step();
        step();
        step();
        auto_rp = 1'b0;
        step();
        chk("auto_drop_idle", {27'd0, outs()}, 32'h0);

        // Abort during LISTEN
        pulses = 8'd1;
        listen = 20'd16;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2 * Half + Blank + 3; i++) step();
        chk("abort_pre", {27'd0, outs()}, 32'h06);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", {27'd0, outs()}, 32'h0);
        chk("abort_cycles", {24'd0, cycles}, {24'd0, cyc_exp()});
        for (int i = 0; i < 16; i++) begin
            chk("abort_quiet", {27'd0, outs()}, 32'h0);
            step();
        end

        // Start during BURST is ignored; burst length unchanged
        pulses = 8'd2;
        listen = 20'd4;
        start  = 1'b1;
        step();
        start = 1'b0;
        ping(2, 4, 5);
        exp_cycles++;
        chk("poke_cycles", {24'd0, cycles}, {24'd0, cyc_exp()});
        step();
        chk("poke_idle", {27'd0, outs()}, 32'h0);

        // Start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", {27'd0, outs()}, 32'h0);

        // Reset mid-burst
        pulses = 8'd3;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("midburst_pre", {27'd0, outs()}, 32'h0A);
        rst = 1'b1;
        step();
        exp_cycles = 8'd0;
        chk("midburst_rst_outs", {27'd0, outs()}, 32'h0);
        chk("midburst_rst_cycles", {24'd0, cycles}, {24'd0, cyc_exp()});
        rst = 1'b0;
        step();

        // 256 short pings: counter wraps
        for (int n = 1; n <= 256; n++) begin
            pulses = 8'd0;
            listen = 20'd1;
            start  = 1'b1;
            step();
            start = 1'b0;
            ping(0, 1, -1);
            exp_cycles++;
            if (n == 255 || n == 256) begin
                chk("wrap_cycles", {24'd0, cycles}, {24'd0, cyc_exp()});
            end
            step();
            chk("wrap_idle", {27'd0, outs()}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
